// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and grant helper for the IF/MEM memory arbiter
//
// Contents:
//   ST_IDLE/ST_BUSY/ST_RESP  arbiter FSM state encodings
//   GNT_IF/GNT_D             granted-requester encodings
//   pick_grant()             IF/MEM arbitration rule used at the grant edge
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  // Data normally wins; after a data grant a pending fetch goes first so a
  // stream of loads/stores cannot starve instruction fetch.
  function automatic logic pick_grant(input logic if_req,
                                      input logic d_req,
                                      input logic last_was_d);
    logic g;
    g = (d_req && (!if_req || !last_was_d)) ? GNT_D : GNT_IF;
    return g;
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// rtl/mem_lat_counter.sv - clear/enable access-latency counter with last-cycle flag
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset, clears the count
//   clr      in   synchronous clear (priority over en)
//   en       in   count enable
//   is_last  out  high while the count equals MEM_LAT-1
module mem_lat_counter #(
  parameter int MEM_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic is_last
);

  // One extra value of headroom: the count steps to MEM_LAT on the final
  // access cycle and then sits there until the next grant clears it.
  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign is_last = (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port fixed-latency memory shared by instruction fetch and load/store
//
// Ports:
//   clk_i, rst_i                     clock (rising) and asynchronous active-low reset
//   if_req_i/if_addr_i               fetch request and address (held until if_ack_o)
//   if_ack_o/if_data_o               one-cycle fetch completion and held instruction word
//   d_req_i/d_we_i/d_addr_i/d_wdata_i  data request, store flag, address, store data
//   d_ack_o/d_rdata_o                one-cycle data completion and held load data
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o  memory command, high for MEM_LAT cycles per access
//   mem_rdata_i                      memory read data, valid in the last enabled cycle
//   stall_o                          pipeline hold while any request is outstanding
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_data_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o
);

  import mem_arb_pkg::*;

  logic [1:0] state;
  logic       gnt;
  logic       last_was_d;
  logic       grant;
  logic       gnt_next;
  logic       in_busy;
  logic       is_last;

  // Arbitration happens only in IDLE; RESP is a dead cycle by design so the
  // requester sees its ack before anything new is granted.
  assign grant    = (state == ST_IDLE) && (if_req_i || d_req_i);
  assign gnt_next = pick_grant(if_req_i, d_req_i, last_was_d);
  assign in_busy  = (state == ST_BUSY);

  mem_lat_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_cnt (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .clr     (grant),
    .en      (in_busy),
    .is_last (is_last)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= ST_IDLE;
      gnt         <= GNT_IF;
      last_was_d  <= 1'b0;
      if_ack_o    <= 1'b0;
      if_data_o   <= '0;
      d_ack_o     <= 1'b0;
      d_rdata_o   <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            state      <= ST_BUSY;
            gnt        <= gnt_next;
            last_was_d <= (gnt_next == GNT_D);
            mem_en_o   <= 1'b1;
            if (gnt_next == GNT_D) begin
              mem_we_o    <= d_we_i;
              mem_addr_o  <= d_addr_i;
              mem_wdata_o <= d_wdata_i;
            end else begin
              mem_we_o    <= 1'b0;
              mem_addr_o  <= if_addr_i;
            end
          end
        end

        ST_BUSY: begin
          if (is_last) begin
            state    <= ST_RESP;
            mem_en_o <= 1'b0;
            mem_we_o <= 1'b0;
            // mem_we_o still reflects the granted access here: it is 1 only
            // for a store, which returns no read data.
            if (gnt == GNT_IF) begin
              if_ack_o  <= 1'b1;
              if_data_o <= mem_rdata_i;
            end else begin
              d_ack_o <= 1'b1;
              if (!mem_we_o) begin
                d_rdata_o <= mem_rdata_i;
              end
            end
          end
        end

        ST_RESP: begin
          state    <= ST_IDLE;
          if_ack_o <= 1'b0;
          d_ack_o  <= 1'b0;
        end

        default: begin
          state    <= ST_IDLE;
          if_ack_o <= 1'b0;
          d_ack_o  <= 1'b0;
          mem_en_o <= 1'b0;
          mem_we_o <= 1'b0;
        end
      endcase
    end
  end

  // Acks are registered, so this has no combinational loop back to the inputs.
  assign stall_o = (if_req_i && !if_ack_o) || (d_req_i && !d_ack_o);

endmodule
